// File: rtl/issue_stage.sv
// issue_stage: holds one decoded instruction, resolves RAW hazards against
// in-flight writes with per-register pending counters, forwards the returning
// writeback and launches the registered operand bundle toward exe_stage.
module issue_stage (
    input  logic        clk,
    input  logic        nrst,
    input  logic        valid3,
    output logic        ready3,
    input  logic [4:0]  rs1_3,
    input  logic [4:0]  rs2_3,
    input  logic [4:0]  rd3,
    input  logic        we3,
    input  logic        use_imm3,
    input  logic        use_pc3,
    input  logic [31:0] imm3,
    input  logic [31:0] pc3,
    input  logic [2:0]  fn3,
    input  logic [3:0]  alu_fn3,
    input  logic        flush,
    input  logic [31:0] wb_data6,
    input  logic        we6,
    input  logic [4:0]  rd6,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [4:0]  rd4,
    output logic        we4,
    output logic [2:0]  fn4,
    output logic [3:0]  alu_fn4,
    output logic [31:0] pc4,
    output logic        valid4
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned PW   = 2;

    typedef struct packed {
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic            we;
        logic            use_imm;
        logic            use_pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [2:0]      fn;
        logic [3:0]      alu_fn;
    } hold_t;

    logic            hold_valid;
    hold_t           hold;
    logic [XLEN-1:0] rf       [NREG];
    logic [PW-1:0]   pend     [NREG];
    logic [PW-1:0]   pend_nxt [NREG];

    logic            rs1_used_c;
    logic            rs2_used_c;
    logic            rs1_fwd_c;
    logic            rs2_fwd_c;
    logic            hazard_c;
    logic            issue_c;
    logic            inc_c;
    logic            dec_c;
    logic            overflow_c;
    logic [XLEN-1:0] src_a_c;
    logic [XLEN-1:0] src_b_c;

    // Hazard detection, forwarding select and operand muxing for the held instruction
    always_comb begin
        rs1_used_c = !hold.use_pc  && (hold.rs1 != '0);
        rs2_used_c = !hold.use_imm && (hold.rs2 != '0);
        // Forward only when the returning write is the last one outstanding
        rs1_fwd_c  = (pend[hold.rs1] == PW'(1)) && we6 && (rd6 == hold.rs1);
        rs2_fwd_c  = (pend[hold.rs2] == PW'(1)) && we6 && (rd6 == hold.rs2);
        hazard_c   = (rs1_used_c && (pend[hold.rs1] != '0) && !rs1_fwd_c) ||
                     (rs2_used_c && (pend[hold.rs2] != '0) && !rs2_fwd_c);
        issue_c    = hold_valid && !hazard_c && !flush;
        ready3     = !hold_valid || issue_c;
        inc_c      = issue_c && hold.we && (hold.rd != '0);
        dec_c      = we6 && (rd6 != '0);

        if (hold.use_pc) begin
            src_a_c = hold.pc;
        end else if (hold.rs1 == '0) begin
            src_a_c = '0;
        end else if (rs1_fwd_c) begin
            src_a_c = wb_data6;
        end else begin
            src_a_c = rf[hold.rs1];
        end

        if (hold.use_imm) begin
            src_b_c = hold.imm;
        end else if (hold.rs2 == '0) begin
            src_b_c = '0;
        end else if (rs2_fwd_c) begin
            src_b_c = wb_data6;
        end else begin
            src_b_c = rf[hold.rs2];
        end
    end

    // Next pending counts: issue increments, writeback decrements, both cancel
    always_comb begin
        overflow_c = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            pend_nxt[i] = pend[i];
            if (inc_c && (hold.rd == RW'(i)) && !(dec_c && (rd6 == RW'(i)))) begin
                pend_nxt[i] = pend[i] + PW'(1);
                if (pend[i] == PW'(3)) begin
                    overflow_c = 1'b1;
                end
            end else if (dec_c && (rd6 == RW'(i)) && !(inc_c && (hold.rd == RW'(i))) &&
                         (pend[i] != '0)) begin
                pend_nxt[i] = pend[i] - PW'(1);
            end
        end
    end

    // Register file and pending counters
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i]   <= '0;
                pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                pend[i] <= pend_nxt[i];
            end
            if (dec_c) begin
                rf[rd6] <= wb_data6;
            end
        end
    end

    // Holding register: flush wins over capture, capture over plain drain
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold_valid <= 1'b0;
            hold       <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (valid3 && ready3) begin
            hold_valid   <= 1'b1;
            hold.rs1     <= rs1_3;
            hold.rs2     <= rs2_3;
            hold.rd      <= rd3;
            hold.we      <= we3;
            hold.use_imm <= use_imm3;
            hold.use_pc  <= use_pc3;
            hold.imm     <= imm3;
            hold.pc      <= pc3;
            hold.fn      <= fn3;
            hold.alu_fn  <= alu_fn3;
        end else if (issue_c) begin
            hold_valid <= 1'b0;
        end
    end

    // Output bundle toward exe_stage: load on issue, otherwise a bubble
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            op_a    <= '0;
            op_b    <= '0;
            rd4     <= '0;
            we4     <= 1'b0;
            fn4     <= '0;
            alu_fn4 <= '0;
            pc4     <= '0;
            valid4  <= 1'b0;
        end else if (issue_c) begin
            op_a    <= src_a_c;
            op_b    <= src_b_c;
            rd4     <= hold.rd;
            we4     <= hold.we;
            fn4     <= hold.fn;
            alu_fn4 <= hold.alu_fn;
            pc4     <= hold.pc;
            valid4  <= 1'b1;
        end else begin
            rd4     <= '0;
            we4     <= 1'b0;
            valid4  <= 1'b0;
        end
    end

    // Fixed in-order latency never allows a fourth outstanding write to one register
    a_pend_overflow: assert property (@(posedge clk) disable iff (!nrst) !overflow_c);

endmodule

// File: doc/issue_stage.md
# issue_stage

Operand-issue stage between decode and `exe_stage`.
- Holds one decoded instruction and reads operands from an internal 32x32 register file.
- Tracks in-flight destination registers with a per-register pending counter, stalls on read-after-write hazards and forwards writeback data.
- Drives the registered operand/control bundle that `exe_stage` samples; absorbs the `wb_data6/we6/rd6` writeback that `exe_stage` returns.

## Interface
Parameters: none (XLEN 32, 32 registers fixed).
- clk  in  1  single clock; all state updates on rising edge
- nrst  in  1  reset, asynchronous, active-low
- valid3  in  1  decode offers an instruction
- ready3  out  1  issue_stage accepts this cycle (combinational)
- rs1_3, rs2_3  in  5 each  source register indices
- rd3  in  5  destination index
- we3  in  1  instruction writes rd
- use_imm3  in  1  op_b takes imm3 instead of rs2
- use_pc3  in  1  op_a takes pc3 instead of rs1
- imm3  in  32  pre-extended immediate
- pc3  in  32  instruction address
- fn3  in  3  writeback select, passed through
- alu_fn3  in  4  ALU op, passed through
- flush  in  1  discard held instruction (branch/jump redirect)
- wb_data6  in  32  writeback value from exe_stage
- we6  in  1  writeback enable
- rd6  in  5  writeback index
- op_a, op_b  out  32  registered operands
- rd4  out  5  registered destination
- we4  out  1  registered write enable
- fn4  out  3  registered writeback select
- alu_fn4  out  4  registered ALU op
- pc4  out  32  registered pc
- valid4  out  1  registered: bundle is a real instruction

## Operation
- Holding register (`hold_valid` + fields) captures decode when `valid3 && ready3`.
- ready3 = !hold_valid || issue.
- Hazard when a used source (rs1 unless use_pc3; rs2 unless use_imm3) is nonzero and has pending count > 1, or pending count == 1 without `we6 && rd6 == rs`.
- issue = hold_valid && !hazard && !flush.
- Operand source for a pending-count-1 register with a matching writeback: wb_data6 (forward). Otherwise: register file.
- Register file is written when `we6 && rd6 != 0`. x0 always reads 0, is never written and is never pending.
- Pending counter is 2-bit per register:
  - +1 on issue with `we && rd != 0`.
  - −1 on `we6 && rd6 != 0`.
  - Both on the same register in one cycle: unchanged.
  - In-order fixed latency bounds the count to 3; 3 + increment without a decrement is an assertion failure.
- Register outputs:
  - On issue: load the selected operands and pass-through fields, and set valid4 = 1.
  - Otherwise: bubble, i.e. valid4 = 0, we4 = 0, rd4 = 0, other outputs hold.
- flush:
  - Clears hold_valid.
  - Suppresses issue that cycle.
  - A same-cycle decode capture is dropped.
  - Instructions already issued complete normally and their writebacks still decrement.

## Timing
- All outputs reset to 0: op_a, op_b, rd4, we4, fn4, alu_fn4, pc4, valid4.
- State reset: hold_valid 0, all register-file entries 0, all pending counters 0.
- Reset is asynchronous. Assertion mid-operation drops the held and in-flight state; writebacks arriving after release are ignored by the counters (already 0; decrement saturates at 0).
- Issue-to-output latency is 1 edge. An instruction captured at edge E and hazard-free issues at E+1.
- Writeback for an instruction issued at edge I arrives (we6 high) in the cycle after I+2.
- A dependent instruction can issue at I+3 via forwarding, so back-to-back RAW costs 2 bubbles.
- Throughput with no hazards: 1 instruction per cycle.
- When the hold register is full and stalled, ready3 = 0 and no new instruction is accepted.
- Register-file write and forwarding happen in the same cycle; a read of the register at the next edge sees the written value.

## Test plan
- Reset:
  - Stimulus: hold nrst low, drive valid3 = 1.
  - Response: all outputs 0 and ready3 = 1.
- Independent stream:
  - Stimulus: x1 = x0 + 5 then x2 = x0 + 7 on consecutive cycles.
  - Response: valid4 high two consecutive cycles, op_b = 5 then 7, no stall.
- RAW forward:
  - Stimulus: x1 ← 0x10 issued at I, then consumer reading x1.
  - Response: consumer valid4 at I+3 with op_a = 0x10, ready3 = 0 for 2 cycles, pending[x1] back to 0.
- Triple WAW to x3 (values 1, 2, 3) then a read of x3.
  - Required pending counts: 3 peak, and the consumer stalls until the last writeback.
  - Required result: op_a = 3.
- Flush while stalled on a hazard:
  - Stimulus: assert flush.
  - Response: held instruction never issues (valid4 stays 0), ready3 = 1 next cycle, earlier writebacks still land in the register file.
- x0 handling:
  - Stimulus: we3 = 1, rd3 = 0 with wb_data6 = 0xFFFF.
  - Response: no stall for later readers of x0, and op_a = 0.
